// File: rtl/crc_check.sv
`default_nettype none
// ============================================================================
//  Module   : crc_check
//  Purpose  : Bit-serial receive-side CRC checker; zero LFSR residue after the
//             data word and received CRC have been shifted in MSB-first.
//  Revision : 1.0
// ============================================================================
module crc_check #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   CRC_WIDTH  = 16,
    parameter logic [CRC_WIDTH-1:0] POLY       = 16'h1021,
    parameter logic [CRC_WIDTH-1:0] INIT       = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [CRC_WIDTH-1:0]  crc_in,
    output logic [CRC_WIDTH-1:0]  crc_calc,
    output logic                  crc_ok,
    output logic                  crc_err,
    output logic                  crc_done
);

    localparam int TOTAL_BITS = DATA_WIDTH + CRC_WIDTH;
    localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

    localparam logic [CNT_W-1:0] c_last_data = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] c_last_bit  = CNT_W'(TOTAL_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [CRC_WIDTH-1:0]    lfsr_q,     lfsr_d;
    logic [CNT_W-1:0]        bit_cnt_q,  bit_cnt_d;
    logic [TOTAL_BITS-1:0]   shreg_q,    shreg_d;
    logic [CRC_WIDTH-1:0]    crc_calc_q, crc_calc_d;
    logic                    crc_ok_q,   crc_ok_d;
    logic                    crc_err_q,  crc_err_d;
    logic                    crc_done_q, crc_done_d;

    logic                    fb;
    logic [CRC_WIDTH-1:0]    lfsr_step;

    // One LFSR step on the bit currently at the head of the shift register.
    always_comb begin
        fb        = lfsr_q[CRC_WIDTH-1] ^ shreg_q[TOTAL_BITS-1];
        lfsr_step = {lfsr_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        crc_calc_d = crc_calc_q;
        crc_ok_d   = crc_ok_q;
        crc_err_d  = crc_err_q;
        crc_done_d = crc_done_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    shreg_d   = {data, crc_in};
                    lfsr_d    = INIT;
                    bit_cnt_d = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    lfsr_d    = lfsr_step;
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == c_last_data) begin
                        crc_calc_d = lfsr_step;
                    end
                    if (bit_cnt_q == c_last_bit) begin
                        crc_ok_d   = (lfsr_step == '0);
                        crc_err_d  = (lfsr_step != '0);
                        crc_done_d = 1'b1;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // crc_calc is deliberately kept until the next accept.
                if (!enable) begin
                    crc_ok_d   = 1'b0;
                    crc_err_d  = 1'b0;
                    crc_done_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= INIT;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            crc_calc_q <= '0;
            crc_ok_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            crc_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            crc_calc_q <= crc_calc_d;
            crc_ok_q   <= crc_ok_d;
            crc_err_q  <= crc_err_d;
            crc_done_q <= crc_done_d;
        end
    end

    assign crc_calc = crc_calc_q;
    assign crc_ok   = crc_ok_q;
    assign crc_err  = crc_err_q;
    assign crc_done = crc_done_q;

endmodule
`default_nettype wire

// File: tb/tb_crc_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_check
//  Purpose  : Directed, table-driven self-checking bench for crc_check.
//  Revision : 1.0
// ============================================================================
module tb_crc_check;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [31:0] data;
    logic [15:0] crc_in;
    logic [15:0] crc_calc;
    logic        crc_ok;
    logic        crc_err;
    logic        crc_done;

    int errors = 0;
    int checks = 0;

    crc_check #(
        .DATA_WIDTH (32),
        .CRC_WIDTH  (16),
        .POLY       (16'h1021),
        .INIT       (16'h0000)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .data     (data),
        .crc_in   (crc_in),
        .crc_calc (crc_calc),
        .crc_ok   (crc_ok),
        .crc_err  (crc_err),
        .crc_done (crc_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [15:0] crc_in;
        logic [15:0] exp_calc;
        logic        exp_ok;
        string       name;
    } vec_t;

    vec_t vecs[8];

    // Reference transmit-side generator: CRC-16 over the data word only.
    function automatic logic [15:0] gen_crc(input logic [31:0] d);
        logic [15:0] r;
        logic        f;
        r = 16'h0000;
        for (int i = 31; i >= 0; i--) begin
            f = r[15] ^ d[i];
            r = {r[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a request, scrambles the inputs afterwards, and checks result,
    // latency, hold-while-enabled and release behaviour.
    task automatic run_vec(input vec_t v);
        int cyc;
        data   = v.data;
        crc_in = v.crc_in;
        enable = 1'b1;
        tick();
        data   = ~v.data;
        crc_in = ~v.crc_in;
        cyc    = 0;
        while (!crc_done && cyc < 100) begin
            tick();
            cyc++;
        end
        check({v.name, " latency"}, cyc, 48);
        check({v.name, " ok"},      crc_ok, v.exp_ok);
        check({v.name, " err"},     crc_err, !v.exp_ok);
        check({v.name, " calc"},    crc_calc, v.exp_calc);
        tick();
        check({v.name, " hold done"}, crc_done, 1);
        check({v.name, " hold ok"},   crc_ok, v.exp_ok);
        enable = 1'b0;
        tick();
        check({v.name, " rel done"}, crc_done, 0);
        check({v.name, " rel flags"}, {crc_ok, crc_err}, 2'b00);
        check({v.name, " rel calc"}, crc_calc, v.exp_calc);
    endtask

    initial begin
        logic [15:0] g;
        logic        seen;
        g = gen_crc(32'h1234_5678);

        vecs[0] = '{32'h0000_0001, 16'h1021, 16'h1021, 1'b1, "v1_good"};
        vecs[1] = '{32'h0000_0001, 16'h1020, 16'h1021, 1'b0, "v2_badcrc"};
        vecs[2] = '{32'h0000_0002, 16'h2042, 16'h2042, 1'b1, "v3_two"};
        vecs[3] = '{32'h0000_0000, 16'h0000, 16'h0000, 1'b1, "v3_zero"};
        vecs[4] = '{32'h1234_5678, g, g, 1'b1, "v4_loop"};
        vecs[5] = '{32'h1234_5679, g, gen_crc(32'h1234_5679), 1'b0, "v4_flip0"};
        vecs[6] = '{32'h9234_5678, g, gen_crc(32'h9234_5678), 1'b0, "v4_flip31"};
        vecs[7] = '{32'h1234_7678, g, gen_crc(32'h1234_7678), 1'b0, "v4_flip13"};

        reset_n = 1'b0;
        enable  = 1'b0;
        data    = '0;
        crc_in  = '0;
        tick();
        tick();
        check("reset outs", {crc_calc, crc_ok, crc_err, crc_done}, 19'h0);
        reset_n = 1'b1;
        tick();
        check("idle outs", {crc_calc, crc_ok, crc_err, crc_done}, 19'h0);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Abort after 20 CALC cycles: no done pulse at all.
        data   = 32'h0000_0001;
        crc_in = 16'h1021;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) tick();
        enable = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (crc_done || crc_ok || crc_err) seen = 1'b1;
        end
        check("abort no done", seen, 0);
        run_vec(vecs[0]);

        // Async reset mid-CALC, after a prior result left crc_calc nonzero.
        data   = 32'h0000_0001;
        crc_in = 16'h1021;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) tick();
        #1 reset_n = 1'b0;
        #1;
        check("rst calc outs", {crc_calc, crc_ok, crc_err, crc_done}, 19'h0);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        run_vec(vecs[2]);

        // Async reset while in DONE.
        data   = 32'h0000_0001;
        crc_in = 16'h1021;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) tick();
        check("pre-rst done", crc_done, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst done outs", {crc_calc, crc_ok, crc_err, crc_done}, 19'h0);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
